// File: rtl/deathrace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deathrace_pkg
// Description : Shared types, VGA bus layout and screen constants for the
//               Death Race sprite and game-logic blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package deathrace_pkg;

    typedef enum logic [1:0] {
        ALIVE   = 2'd0,
        DEAD    = 2'd1,
        RESPAWN = 2'd2
    } grem_state_t;

    localparam int SCORE_W = 10;
    localparam int POS_W   = 11;
    localparam int OVL_W   = 8;

    // VGA timing bus: {vblnk, vsync, vcount[10:0], hblnk, hsync, hcount[10:0]}
    localparam int VGA_BUS_SIZE   = 26;
    localparam int VGA_HCOUNT_LSB = 0;
    localparam int VGA_HSYNC_BIT  = 11;
    localparam int VGA_HBLNK_BIT  = 12;
    localparam int VGA_VCOUNT_LSB = 13;
    localparam int VGA_VSYNC_BIT  = 24;
    localparam int VGA_VBLNK_BIT  = 25;

    localparam int SCREEN_X_MIN = 0;
    localparam int SCREEN_X_MAX = 799;
    localparam int SCREEN_Y_MIN = 0;
    localparam int SCREEN_Y_MAX = 599;

    function automatic logic [SCORE_W-1:0] score_sat_inc(
        input logic [SCORE_W-1:0] cur,
        input logic [SCORE_W-1:0] max_val
    );
        return (cur >= max_val) ? cur : cur + SCORE_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : frame_tick_gen
// Description : Single-cycle start-of-frame strobe on the rising edge of vsync.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_tick
);

    logic r_vsync_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsync_d <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
        end
    end

    assign frame_tick = vsync & ~r_vsync_d;

endmodule
`default_nettype wire

// File: rtl/gremlin_hit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gremlin_hit_ctrl
// Description : Car/gremlin collision counter, score keeper and respawn timer.
// Revision    : 1.0 - initial release
// ============================================================================
module gremlin_hit_ctrl
    import deathrace_pkg::*;
#(
    parameter int DEAD_FRAMES = 60,
    parameter int MIN_OVERLAP = 4,
    parameter int SCORE_MAX   = 999
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [VGA_BUS_SIZE-1:0] vga_in,
    input  logic                    car_color,
    input  logic                    grem_color,
    input  logic [POS_W-1:0]        grem_xpos,
    input  logic [POS_W-1:0]        grem_ypos,
    output logic                    hit,
    output logic                    grem_dead,
    output logic                    grem,
    output logic [POS_W-1:0]        tomb_xpos,
    output logic [POS_W-1:0]        tomb_ypos,
    output logic [SCORE_W-1:0]      score
);

    localparam logic [1:0]         c_ST_ALIVE    = ALIVE;
    localparam logic [1:0]         c_ST_DEAD     = DEAD;
    localparam logic [1:0]         c_ST_RESPAWN  = RESPAWN;
    localparam logic [OVL_W-1:0]   c_DEAD_FRAMES = OVL_W'(DEAD_FRAMES);
    localparam logic [OVL_W-1:0]   c_MIN_OVERLAP = OVL_W'(MIN_OVERLAP);
    localparam logic [OVL_W-1:0]   c_OVL_MAX     = '1;
    localparam logic [SCORE_W-1:0] c_SCORE_MAX   = SCORE_W'(SCORE_MAX);

    logic w_vsync;
    logic w_hblnk;
    logic w_vblnk;
    logic w_frame_tick;
    logic w_pixel_ovl;
    logic w_kill;
    logic w_respawn;
    logic w_unused_vga;
    logic [1:0] w_state_nxt;

    logic [1:0]         r_state;
    logic [OVL_W-1:0]   r_ovl;
    logic [OVL_W-1:0]   r_dead_cnt;
    logic               r_armed;
    logic               r_hit;
    logic               r_grem;
    logic               r_grem_dead;
    logic [POS_W-1:0]   r_tomb_x;
    logic [POS_W-1:0]   r_tomb_y;
    logic [SCORE_W-1:0] r_score;

    assign w_vsync = vga_in[VGA_VSYNC_BIT];
    assign w_hblnk = vga_in[VGA_HBLNK_BIT];
    assign w_vblnk = vga_in[VGA_VBLNK_BIT];
    assign w_unused_vga = &{1'b0, vga_in[VGA_HBLNK_BIT-1:0],
                            vga_in[VGA_VSYNC_BIT-1:VGA_VCOUNT_LSB]};

    frame_tick_gen u_frame_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .vsync      (w_vsync),
        .frame_tick (w_frame_tick)
    );

    assign w_pixel_ovl = ~w_hblnk & ~w_vblnk & car_color & grem_color;

    // r_armed stays low until the first tick so a partial frame after reset
    // can never produce a kill.
    assign w_kill    = (r_state == c_ST_ALIVE) & w_frame_tick & r_armed &
                       (r_ovl >= c_MIN_OVERLAP);
    assign w_respawn = (r_state == c_ST_DEAD) & w_frame_tick &
                       (r_dead_cnt == OVL_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_ALIVE:   if (w_kill)    w_state_nxt = c_ST_DEAD;
            c_ST_DEAD:    if (w_respawn) w_state_nxt = c_ST_RESPAWN;
            c_ST_RESPAWN: w_state_nxt = c_ST_ALIVE;
            default:      w_state_nxt = c_ST_ALIVE;
        endcase
    end

    // The tick clears the count and drops any pixel landing on that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovl   <= '0;
            r_armed <= 1'b0;
        end else if (w_frame_tick) begin
            r_ovl   <= '0;
            r_armed <= 1'b1;
        end else if (w_pixel_ovl && (r_ovl != c_OVL_MAX)) begin
            r_ovl <= r_ovl + OVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_ALIVE;
            r_dead_cnt  <= '0;
            r_hit       <= 1'b0;
            r_grem      <= 1'b0;
            r_grem_dead <= 1'b0;
            r_tomb_x    <= '0;
            r_tomb_y    <= '0;
            r_score     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hit       <= w_kill;
            r_grem      <= w_respawn;
            r_grem_dead <= (w_state_nxt != c_ST_ALIVE);
            if (w_kill) begin
                r_dead_cnt <= c_DEAD_FRAMES;
                r_tomb_x   <= grem_xpos;
                r_tomb_y   <= grem_ypos;
                r_score    <= score_sat_inc(r_score, c_SCORE_MAX);
            end else if ((r_state == c_ST_DEAD) && w_frame_tick &&
                         (r_dead_cnt != '0)) begin
                r_dead_cnt <= r_dead_cnt - OVL_W'(1);
            end
        end
    end

    assign hit       = r_hit;
    assign grem      = r_grem;
    assign grem_dead = r_grem_dead;
    assign tomb_xpos = r_tomb_x;
    assign tomb_ypos = r_tomb_y;
    assign score     = r_score;

endmodule
`default_nettype wire

// File: tb/tb_gremlin_hit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gremlin_hit_ctrl
// Description : Randomized frame-level bench for gremlin_hit_ctrl with a
//               frame-granular reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gremlin_hit_ctrl;
    import deathrace_pkg::*;

    localparam int DEAD_FRAMES = 3;
    localparam int MIN_OVERLAP = 4;
    localparam int SCORE_MAX   = 999;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [VGA_BUS_SIZE-1:0] vga_in;
    logic                    car_color;
    logic                    grem_color;
    logic [10:0]             grem_xpos;
    logic [10:0]             grem_ypos;
    logic                    hit;
    logic                    grem_dead;
    logic                    grem;
    logic [10:0]             tomb_xpos;
    logic [10:0]             tomb_ypos;
    logic [9:0]              score;

    int n_cmp = 0;
    int n_err = 0;
    int grem_pulses = 0;
    int hit_pulses  = 0;

    // Reference model: frame-granular game state
    bit m_armed;
    bit m_alive;
    int m_dead_left;
    int m_score;
    int m_tx;
    int m_ty;

    gremlin_hit_ctrl #(
        .DEAD_FRAMES (DEAD_FRAMES),
        .MIN_OVERLAP (MIN_OVERLAP),
        .SCORE_MAX   (SCORE_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vga_in     (vga_in),
        .car_color  (car_color),
        .grem_color (grem_color),
        .grem_xpos  (grem_xpos),
        .grem_ypos  (grem_ypos),
        .hit        (hit),
        .grem_dead  (grem_dead),
        .grem       (grem),
        .tomb_xpos  (tomb_xpos),
        .tomb_ypos  (tomb_ypos),
        .score      (score)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (grem === 1'b1) grem_pulses++;
        if (hit === 1'b1)  hit_pulses++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input bit vs, input bit hb, input bit vb,
                         input bit car, input bit gr);
        vga_in                = '0;
        vga_in[VGA_VSYNC_BIT] = vs;
        vga_in[VGA_HBLNK_BIT] = hb;
        vga_in[VGA_VBLNK_BIT] = vb;
        car_color             = car;
        grem_color            = gr;
    endtask

    task automatic model_reset();
        m_armed = 0; m_alive = 1; m_dead_left = 0;
        m_score = 0; m_tx = 0; m_ty = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1, 1, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One frame: active pixels (n_ovl overlapping, n_extra non-counting),
    // a vsync cycle, and two blank trailing cycles where the tick's effects are checked.
    task automatic run_frame(input int n_ovl, input int n_extra, input int x,
                             input int y, input bit tick_pix, input string tag);
        int  ro, re, kind, ovl_eff;
        bit  stray, e_hit, e_grem, e_dead1, e_dead2, respawning;
        stray = 0; ro = n_ovl; re = n_extra;
        grem_xpos = 11'(x);
        grem_ypos = 11'(y);
        while (ro + re > 0) begin
            @(negedge clk);
            if (hit !== 1'b0 || grem !== 1'b0 || grem_dead !== !m_alive) stray = 1;
            if (ro > 0 && (re == 0 || $urandom_range(ro + re - 1) < ro)) begin
                drive(0, 0, 0, 1, 1);
                ro--;
            end else begin
                kind = $urandom_range(4);
                case (kind)
                    0: drive(0, 0, 0, 1, 0);
                    1: drive(0, 0, 0, 0, 1);
                    2: drive(0, 0, 0, 0, 0);
                    3: drive(0, 1, 0, 1, 1);
                    default: drive(0, 0, 1, 1, 1);
                endcase
                re--;
            end
        end
        @(negedge clk);
        if (hit !== 1'b0 || grem !== 1'b0 || grem_dead !== !m_alive) stray = 1;
        if (tick_pix) drive(1, 0, 0, 1, 1);
        else          drive(1, 0, 1, 1'($urandom_range(1)), 1'($urandom_range(1)));

        ovl_eff = (n_ovl > 255) ? 255 : n_ovl;
        e_hit = 0; e_grem = 0; respawning = 0;
        if (!m_armed) begin
            m_armed = 1;
        end else if (m_alive) begin
            if (ovl_eff >= MIN_OVERLAP) begin
                e_hit = 1;
                m_alive = 0;
                m_dead_left = DEAD_FRAMES;
                m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
                m_tx = x; m_ty = y;
            end
        end else begin
            m_dead_left--;
            if (m_dead_left == 0) begin
                e_grem = 1; respawning = 1; m_alive = 1;
            end
        end
        e_dead1 = !m_alive || respawning;
        e_dead2 = !m_alive;

        @(negedge clk);
        drive(0, 1, 1, 0, 0);
        n_cmp++;
        if (hit !== e_hit) begin
            n_err++; $display("FAIL %s.hit: got %0b expected %0b", tag, hit, e_hit);
        end
        n_cmp++;
        if (grem !== e_grem) begin
            n_err++; $display("FAIL %s.grem: got %0b expected %0b", tag, grem, e_grem);
        end
        n_cmp++;
        if (grem_dead !== e_dead1) begin
            n_err++; $display("FAIL %s.grem_dead: got %0b expected %0b", tag, grem_dead, e_dead1);
        end
        n_cmp++;
        if (score !== 10'(m_score)) begin
            n_err++; $display("FAIL %s.score: got %0d expected %0d", tag, score, m_score);
        end
        n_cmp++;
        if (tomb_xpos !== 11'(m_tx) || tomb_ypos !== 11'(m_ty)) begin
            n_err++;
            $display("FAIL %s.tomb: got (%0d,%0d) expected (%0d,%0d)",
                     tag, tomb_xpos, tomb_ypos, m_tx, m_ty);
        end
        @(negedge clk);
        n_cmp++;
        if (hit !== 1'b0 || grem !== 1'b0 || grem_dead !== e_dead2) begin
            n_err++;
            $display("FAIL %s.after_tick: got hit=%0b grem=%0b dead=%0b expected 0 0 %0b",
                     tag, hit, grem, grem_dead, e_dead2);
        end
        n_cmp++;
        if (stray !== 1'b0) begin
            n_err++;
            $display("FAIL %s.mid_frame: got stray output activity=1 expected 0", tag);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({hit, grem, grem_dead} !== 3'b000) begin
            n_err++; $display("FAIL reset.flags: got %03b expected 000", {hit, grem, grem_dead});
        end
        n_cmp++;
        if (score !== 10'd0) begin
            n_err++; $display("FAIL reset.score: got %0d expected 0", score);
        end
        n_cmp++;
        if (tomb_xpos !== 11'd0 || tomb_ypos !== 11'd0) begin
            n_err++; $display("FAIL reset.tomb: got (%0d,%0d) expected (0,0)", tomb_xpos, tomb_ypos);
        end
    endtask

    task automatic test_idle();
        int h0, g0;
        h0 = hit_pulses; g0 = grem_pulses;
        run_frame(10, 3, 100, 100, 0, "first_tick");
        for (int i = 0; i < 3; i++)
            run_frame(0, 2 + $urandom_range(6), 120, 130, 0, "idle");
        n_cmp++;
        if (hit_pulses != h0 || grem_pulses != g0 || score !== 10'd0) begin
            n_err++;
            $display("FAIL idle.quiet: got hits=%0d grems=%0d score=%0d expected 0 0 0",
                     hit_pulses - h0, grem_pulses - g0, score);
        end
    endtask

    task automatic test_threshold();
        run_frame(3, 4, 200, 200, 0, "ovl3");
        run_frame(2, 3, 200, 200, 1, "ovl2_tickpix");
        run_frame(3, 2, 200, 200, 0, "ovl3_after_tickpix");
        run_frame(4, 3, 210, 220, 0, "ovl4");
        n_cmp++;
        if (score !== 10'd1) begin
            n_err++; $display("FAIL threshold.score: got %0d expected 1", score);
        end
        for (int i = 0; i < DEAD_FRAMES; i++)
            run_frame(0, 2, 210, 220, 0, "threshold_dead");
    endtask

    task automatic test_tombstone();
        run_frame(6, 2, 400, 300, 0, "tomb_kill");
        for (int i = 0; i < DEAD_FRAMES; i++)
            run_frame(0, 2, 400, 300, 0, "tomb_dead");
        for (int i = 0; i < 2; i++)
            run_frame(0, 3, 410, 290, 0, "tomb_moved");
        n_cmp++;
        if (tomb_xpos !== 11'd400 || tomb_ypos !== 11'd300) begin
            n_err++; $display("FAIL tomb.held: got (%0d,%0d) expected (400,300)", tomb_xpos, tomb_ypos);
        end
    endtask

    task automatic test_dead_frames();
        int g0, h0;
        run_frame(5, 1, 50, 60, 0, "df_kill");
        g0 = grem_pulses; h0 = hit_pulses;
        for (int i = 0; i < DEAD_FRAMES; i++)
            run_frame(8, 2, 55, 65, 0, "df_dead_ovl");
        n_cmp++;
        if (grem_pulses - g0 != 1 || hit_pulses != h0) begin
            n_err++;
            $display("FAIL dead.pulses: got grem=%0d hit=%0d expected grem=1 hit=0",
                     grem_pulses - g0, hit_pulses - h0);
        end
    endtask

    task automatic test_reset_in_dead();
        int g0;
        run_frame(4, 0, 70, 80, 0, "rd_kill");
        run_frame(0, 2, 70, 80, 0, "rd_dead");
        repeat (3) begin
            @(negedge clk);
            drive(0, 0, 0, 1, 1);
        end
        do_reset();
        n_cmp++;
        if (grem_dead !== 1'b0 || score !== 10'd0 || grem !== 1'b0) begin
            n_err++;
            $display("FAIL reset_dead.state: got dead=%0b score=%0d grem=%0b expected 0 0 0",
                     grem_dead, score, grem);
        end
        g0 = grem_pulses;
        for (int i = 0; i < 5; i++)
            run_frame(0, 3, 90, 90, 0, "rd_after");
        n_cmp++;
        if (grem_pulses != g0) begin
            n_err++; $display("FAIL reset_dead.no_grem: got %0d pulses expected 0", grem_pulses - g0);
        end
    endtask

    task automatic test_ovl_saturate();
        run_frame(256, 0, 300, 310, 0, "ovl256");
        for (int i = 0; i < DEAD_FRAMES; i++)
            run_frame(0, 1, 300, 310, 0, "ovl256_dead");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            run_frame($urandom_range(6), $urandom_range(6), $urandom_range(2047),
                      $urandom_range(2047), 1'($urandom_range(3) == 0), "random");
    endtask

    task automatic test_score_saturate();
        int h0;
        do_reset();
        run_frame(0, 1, 0, 0, 0, "sat_prime");
        while (m_score < SCORE_MAX - 1) begin
            run_frame(4, 1, $urandom_range(2047), $urandom_range(2047), 0, "sat_preload");
            for (int i = 0; i < DEAD_FRAMES; i++)
                run_frame(0, 0, 0, 0, 0, "sat_preload_dead");
        end
        h0 = hit_pulses;
        for (int k = 0; k < 3; k++) begin
            run_frame(5, 1, 500 + k, 200 + k, 0, "sat_kill");
            n_cmp++;
            if (score !== 10'd999) begin
                n_err++; $display("FAIL sat.score: got %0d expected 999", score);
            end
            for (int i = 0; i < DEAD_FRAMES; i++)
                run_frame(0, 1, 0, 0, 0, "sat_dead");
        end
        n_cmp++;
        if (hit_pulses - h0 != 3) begin
            n_err++; $display("FAIL sat.hits: got %0d expected 3", hit_pulses - h0);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1, 1, 0, 0);
        grem_xpos = '0;
        grem_ypos = '0;
        model_reset();
        test_reset();
        test_idle();
        test_threshold();
        test_tombstone();
        test_dead_frames();
        test_reset_in_dead();
        test_ovl_saturate();
        test_random();
        test_score_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
